// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex display driver: scans DIGITS common-anode digits, PRESCALE clocks each.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt, cnt_next;
  logic [IW-1:0]       idx, idx_next;
  logic [4*DIGITS-1:0] val_hold;
  logic [DIGITS-1:0]   dp_hold;
  logic                cnt_wrap, idx_wrap;
  logic [3:0]          digit_arr [DIGITS];
  logic [3:0]          cur_digit;
  logic [6:0]          seg_code, seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_next;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = val_hold[4*gi +: 4];
    end
  endgenerate

`ifdef HEX_SCAN_LZB_EN
  // A digit is blank when it and every more-significant held digit are zero.
  logic [DIGITS-1:0] blank;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = ~|val_hold[4*DIGITS-1:4*gi];
      end
    end
  endgenerate
`endif

  always_comb begin
    cnt_wrap  = (cnt == CNT_LAST);
    idx_wrap  = (idx == IDX_LAST);
    cnt_next  = cnt_wrap ? '0 : cnt + 1'b1;
    idx_next  = idx;
    if (cnt_wrap) begin
      idx_next = idx_wrap ? '0 : idx + 1'b1;
    end

    cur_digit = digit_arr[idx];
    case (cur_digit)
      4'h0:    seg_code = 7'h40;
      4'h1:    seg_code = 7'h79;
      4'h2:    seg_code = 7'h24;
      4'h3:    seg_code = 7'h30;
      4'h4:    seg_code = 7'h19;
      4'h5:    seg_code = 7'h12;
      4'h6:    seg_code = 7'h02;
      4'h7:    seg_code = 7'h78;
      4'h8:    seg_code = 7'h00;
      4'h9:    seg_code = 7'h18;
      4'hA:    seg_code = 7'h08;
      4'hB:    seg_code = 7'h03;
      4'hC:    seg_code = 7'h46;
      4'hD:    seg_code = 7'h21;
      4'hE:    seg_code = 7'h06;
      default: seg_code = 7'h0E;
    endcase

    // First cycle of every slot is dark so the previous digit cannot ghost.
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    an_next  = '1;
    if (cnt != '0) begin
      an_next[idx] = 1'b0;
      dp_next      = ~dp_hold[idx];
      seg_next     = seg_code;
`ifdef HEX_SCAN_LZB_EN
      if (blank[idx]) begin
        seg_next = 7'h7F;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      idx        <= '0;
      val_hold   <= '0;
      dp_hold    <= '0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        val_hold <= value;
        dp_hold  <= dp;
      end
      cnt        <= cnt_next;
      idx        <= idx_next;
      seg_n      <= seg_next;
      dp_n       <= dp_next;
      an_n       <= an_next;
      frame_tick <= cnt_wrap && idx_wrap;
    end
  end

endmodule
